// File: rtl/mask_bbox_tracker_pkg.sv
// ---------------------------------------------------------------------------
// mask_bbox_tracker_pkg
//   Shared definitions for the mask bounding-box tracker:
//   - default active frame size (H_ACT_DEF x V_ACT_DEF)
//   - coordinate and pixel-count widths
//   - empty-box sentinels (min = all ones, max = zero)
//   - tracker FSM state encoding
//   - bbox_t: packed bounding box + pixel count record
// ---------------------------------------------------------------------------
package mask_bbox_tracker_pkg;

    localparam int COORD_W   = 10;
    localparam int CNT_W     = 20;
    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    // Empty sentinels: any real coordinate pulls min down and max up.
    localparam logic [COORD_W-1:0] MIN_EMPTY = '1;
    localparam logic [COORD_W-1:0] MAX_EMPTY = '0;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } trk_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
        logic [CNT_W-1:0]   cnt;
    } bbox_t;

    localparam bbox_t BBOX_EMPTY = '{
        xmin: MIN_EMPTY,
        xmax: MAX_EMPTY,
        ymin: MIN_EMPTY,
        ymax: MAX_EMPTY,
        cnt:  '0
    };

endpackage

// File: rtl/mask_bbox_tracker_run_filter.sv
// ---------------------------------------------------------------------------
// mask_run_filter
//   Horizontal run-length noise filter for the foreground mask stream.
//   Tracks the length of the current run of consecutive foreground pixels
//   (mask=0) along a row and only lets pixels through once the run has
//   reached MIN_RUN pixels.
//
//   Ports:
//     clk_25, rst_n    pixel clock, asynchronous active-low reset
//     valid            pixel strobe; state only advances on valid pixels
//     mask             0 = foreground, 1 = background
//     mask_x           pixel column
//     accept           current pixel extends a run already at/over MIN_RUN
//                      (count it alone)
//     accept_burst     current pixel brings the run to exactly MIN_RUN
//                      (count the whole MIN_RUN pixels at once)
//     run_start        first column of the run containing the current pixel
// ---------------------------------------------------------------------------
module mask_run_filter
    import mask_bbox_tracker_pkg::*;
#(
    parameter int MIN_RUN = 4
) (
    input  logic               clk_25,
    input  logic               rst_n,
    input  logic               valid,
    input  logic               mask,
    input  logic [COORD_W-1:0] mask_x,
    output logic               accept,
    output logic               accept_burst,
    output logic [COORD_W-1:0] run_start
);

    localparam logic [3:0] MIN_RUN_L = 4'(MIN_RUN);

    logic [3:0]         run_len;
    logic [3:0]         run_len_next;
    logic [COORD_W-1:0] prev_x;
    logic [COORD_W-1:0] start_q;
    logic [COORD_W:0]   prev_x_inc;
    logic               contiguous;
    logic               extend;
    logic               was_accepting;

    always_comb begin
        // One extra bit so prev_x=3FF never wraps onto column 0.
        prev_x_inc    = {1'b0, prev_x} + {{COORD_W{1'b0}}, 1'b1};
        contiguous    = ({1'b0, mask_x} == prev_x_inc);
        extend        = !mask && contiguous && (run_len != 4'd0);
        was_accepting = extend && (run_len >= MIN_RUN_L);

        run_len_next = 4'd0;
        run_start    = start_q;
        if (mask) begin
            run_len_next = 4'd0;
        end else if (extend) begin
            run_len_next = (run_len == 4'hF) ? 4'hF : run_len + 4'd1;
        end else begin
            run_len_next = 4'd1;
            run_start    = mask_x;
        end

        // Saturation can pin run_len at MIN_RUN (MIN_RUN=15), so the burst
        // is qualified on the run not having been accepted already.
        accept       = valid && was_accepting;
        accept_burst = valid && !mask && (run_len_next == MIN_RUN_L) && !was_accepting;
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            run_len <= 4'd0;
            prev_x  <= '1;
            start_q <= '0;
        end else if (valid) begin
            run_len <= run_len_next;
            prev_x  <= mask_x;
            start_q <= run_start;
        end
    end

endmodule

// File: rtl/mask_bbox_tracker.sv
// ---------------------------------------------------------------------------
// mask_bbox_tracker
//   Per-frame bounding box and pixel count of noise-filtered foreground in
//   the mask stream, published once per frame over a level/ack handshake.
//
//   Ports:
//     clk_25, rst_n      pixel clock, asynchronous active-low reset
//     enable             tracking enable, looked at only on frame start
//     min_count          minimum pixel count for obj_found
//     valid/mask         pixel strobe and mask bit (0 = foreground)
//     mask_x/mask_y      pixel coordinates
//     result_valid       output registers hold an unacknowledged result
//     result_ack         clears result_valid
//     result_ovf         sticky: a result overwrote an unacknowledged one
//     obj_found          pix_count >= min_count and pix_count != 0
//     x_min..y_max       bounding box (empty: min=3FF, max=0)
//     pix_count          accepted foreground pixels in the frame
//     sync_err           one-cycle pulse: frame start seen mid-frame
// ---------------------------------------------------------------------------
module mask_bbox_tracker
    import mask_bbox_tracker_pkg::*;
#(
    parameter int H_ACT   = H_ACT_DEF,
    parameter int V_ACT   = V_ACT_DEF,
    parameter int MIN_RUN = 4
) (
    input  logic               clk_25,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [CNT_W-1:0]   min_count,
    input  logic               valid,
    input  logic               mask,
    input  logic [COORD_W-1:0] mask_x,
    input  logic [COORD_W-1:0] mask_y,
    output logic               result_valid,
    input  logic               result_ack,
    output logic               result_ovf,
    output logic               obj_found,
    output logic [COORD_W-1:0] x_min,
    output logic [COORD_W-1:0] x_max,
    output logic [COORD_W-1:0] y_min,
    output logic [COORD_W-1:0] y_max,
    output logic [CNT_W-1:0]   pix_count,
    output logic               sync_err
);

    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_ACT - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_ACT - 1);
    localparam logic [4:0]         BURST_INC = 5'(MIN_RUN);

    trk_state_t         state;
    bbox_t              acc;
    bbox_t              res;
    bbox_t              acc_from_cur;
    bbox_t              acc_from_clr;
    logic               accept;
    logic               accept_burst;
    logic [COORD_W-1:0] run_start;
    logic               fs;
    logic               fe;

    function automatic logic [COORD_W-1:0] cmin(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

    function automatic logic [COORD_W-1:0] cmax(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [4:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-4){1'b0}}, b};
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    // Fold one filtered pixel into a box. A burst credits the whole run that
    // just qualified, so x_min comes from the run start, not this pixel.
    function automatic bbox_t bbox_add(input bbox_t              b,
                                       input logic               burst,
                                       input logic               one,
                                       input logic [COORD_W-1:0] start,
                                       input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        bbox_t r;
        r = b;
        if (burst) begin
            r.cnt  = sat_add(b.cnt, BURST_INC);
            r.xmin = cmin(b.xmin, start);
        end else if (one) begin
            r.cnt  = sat_add(b.cnt, 5'd1);
        end
        if (burst || one) begin
            r.xmax = cmax(b.xmax, x);
            r.ymin = cmin(b.ymin, y);
            r.ymax = cmax(b.ymax, y);
        end
        return r;
    endfunction

    mask_run_filter #(
        .MIN_RUN (MIN_RUN)
    ) u_run_filter (
        .clk_25       (clk_25),
        .rst_n        (rst_n),
        .valid        (valid),
        .mask         (mask),
        .mask_x       (mask_x),
        .accept       (accept),
        .accept_burst (accept_burst),
        .run_start    (run_start)
    );

    assign fs = valid && (mask_x == '0)     && (mask_y == '0);
    assign fe = valid && (mask_x == X_LAST) && (mask_y == Y_LAST);

    // Frame-start pixels are folded into freshly cleared accumulators.
    assign acc_from_cur = bbox_add(acc,        accept_burst, accept, run_start, mask_x, mask_y);
    assign acc_from_clr = bbox_add(BBOX_EMPTY, accept_burst, accept, run_start, mask_x, mask_y);

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            acc          <= BBOX_EMPTY;
            res          <= BBOX_EMPTY;
            obj_found    <= 1'b0;
            result_valid <= 1'b0;
            result_ovf   <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            sync_err <= 1'b0;

            // Publishing outranks a simultaneous ack.
            if (state != ST_PUBLISH && result_ack) begin
                result_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (fs && enable) begin
                        acc   <= acc_from_clr;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (fe) begin
                        acc   <= acc_from_cur;
                        state <= ST_PUBLISH;
                    end else if (fs) begin
                        sync_err <= 1'b1;
                        acc      <= acc_from_clr;
                        if (!enable) begin
                            state <= ST_IDLE;
                        end
                    end else if (valid) begin
                        acc <= acc_from_cur;
                    end
                end
                ST_PUBLISH: begin
                    res          <= acc;
                    obj_found    <= (acc.cnt >= min_count) && (acc.cnt != '0);
                    result_valid <= 1'b1;
                    result_ovf   <= result_ovf | (result_valid & ~result_ack);
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_min     = res.xmin;
    assign x_max     = res.xmax;
    assign y_min     = res.ymin;
    assign y_max     = res.ymax;
    assign pix_count = res.cnt;

endmodule

// File: tb/tb_mask_bbox_tracker.sv
// ---------------------------------------------------------------------------
// tb_mask_bbox_tracker
//   Self-checking bench for mask_bbox_tracker (640x480, MIN_RUN=4).
//   Frames are pixel sequences; the reference model keeps the accepted
//   frame's pixels and derives the result by grouping consecutive
//   foreground pixels into runs. A negedge compare process checks every
//   output every cycle; literal checks pin the directed scenarios.
// ---------------------------------------------------------------------------
module tb_mask_bbox_tracker;

    localparam int MIN_RUN = 4;
    localparam int XL      = 639;
    localparam int YL      = 479;

    logic        clk_25 = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [19:0] min_count;
    logic        valid;
    logic        mask;
    logic [9:0]  mask_x;
    logic [9:0]  mask_y;
    logic        result_ack;
    logic        result_valid;
    logic        result_ovf;
    logic        obj_found;
    logic [9:0]  x_min, x_max, y_min, y_max;
    logic [19:0] pix_count;
    logic        sync_err;

    int n_cmp = 0;
    int n_bad = 0;
    int sync_hi = 0;
    bit ack_rand = 1'b0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       m;
    } pix_t;

    pix_t stim[$];
    pix_t fq[$];

    // reference model state
    bit          armed, pub_pend;
    logic        exp_rv, exp_ovf, exp_found, exp_sync;
    logic [9:0]  exp_xmin, exp_xmax, exp_ymin, exp_ymax;
    logic [19:0] exp_cnt;

    mask_bbox_tracker #(
        .H_ACT   (640),
        .V_ACT   (480),
        .MIN_RUN (MIN_RUN)
    ) dut (
        .clk_25       (clk_25),
        .rst_n        (rst_n),
        .enable       (enable),
        .min_count    (min_count),
        .valid        (valid),
        .mask         (mask),
        .mask_x       (mask_x),
        .mask_y       (mask_y),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .result_ovf   (result_ovf),
        .obj_found    (obj_found),
        .x_min        (x_min),
        .x_max        (x_max),
        .y_min        (y_min),
        .y_max        (y_max),
        .pix_count    (pix_count),
        .sync_err     (sync_err)
    );

    always #20 clk_25 = ~clk_25;

    task automatic reset_model();
        armed = 0; pub_pend = 0; fq.delete();
        exp_rv = 0; exp_ovf = 0; exp_found = 0; exp_sync = 0;
        exp_xmin = 10'h3FF; exp_ymin = 10'h3FF; exp_xmax = 0; exp_ymax = 0; exp_cnt = 0;
    endtask

    // Result of a frame: every maximal run of foreground pixels at
    // consecutive columns that is at least MIN_RUN long counts in full.
    function automatic void calc_frame(output logic [9:0] xa, output logic [9:0] xb,
                                       output logic [9:0] ya, output logic [9:0] yb,
                                       output logic [19:0] c);
        int i, j, n, tot;
        xa = 10'h3FF; xb = 0; ya = 10'h3FF; yb = 0; tot = 0;
        n = fq.size(); i = 0;
        while (i < n) begin
            if (fq[i].m) begin
                i++;
            end else begin
                j = i;
                while (j + 1 < n && !fq[j+1].m && int'(fq[j+1].x) == int'(fq[j].x) + 1) j++;
                if (j - i + 1 >= MIN_RUN) begin
                    tot += j - i + 1;
                    for (int k = i; k <= j; k++) begin
                        if (fq[k].x < xa) xa = fq[k].x;
                        if (fq[k].x > xb) xb = fq[k].x;
                        if (fq[k].y < ya) ya = fq[k].y;
                        if (fq[k].y > yb) yb = fq[k].y;
                    end
                end
                i = j + 1;
            end
        end
        c = (tot > 20'hFFFFF) ? 20'hFFFFF : 20'(tot);
    endfunction

    // Expected outputs after one clock edge with the given sampled inputs.
    task automatic model_edge(input logic v, input logic m, input logic [9:0] x,
                              input logic [9:0] y, input logic a);
        bit   was_pub;
        bit   is_fs, is_fe;
        pix_t p;
        was_pub  = pub_pend;
        exp_sync = 0;
        if (was_pub) begin
            calc_frame(exp_xmin, exp_xmax, exp_ymin, exp_ymax, exp_cnt);
            exp_found = (exp_cnt >= min_count) && (exp_cnt != 0);
            exp_ovf   = exp_ovf | (exp_rv & ~a);
            exp_rv    = 1;
            pub_pend  = 0;
            armed     = 0;
        end else if (a) begin
            exp_rv = 0;
        end
        if (v && !was_pub) begin
            p.x = x; p.y = y; p.m = m;
            is_fs = (x == 0) && (y == 0);
            is_fe = (x == XL) && (y == YL);
            if (!armed) begin
                if (is_fs && enable) begin
                    armed = 1; fq.delete(); fq.push_back(p);
                end
            end else if (is_fe) begin
                fq.push_back(p); pub_pend = 1;
            end else if (is_fs) begin
                exp_sync = 1; fq.delete();
                if (enable) fq.push_back(p);
                else armed = 0;
            end else begin
                fq.push_back(p);
            end
        end
    endtask

    always @(negedge clk_25) begin
        if (sync_err) sync_hi++;
        n_cmp++;
        if ({result_valid, result_ovf, obj_found, sync_err, x_min, x_max, y_min, y_max, pix_count} !==
            {exp_rv, exp_ovf, exp_found, exp_sync, exp_xmin, exp_xmax, exp_ymin, exp_ymax, exp_cnt}) begin
            n_bad++;
            $display("FAIL cycle_cmp t=%0t got rv=%b ovf=%b found=%b sync=%b box=%0d..%0d,%0d..%0d cnt=%0d expected rv=%b ovf=%b found=%b sync=%b box=%0d..%0d,%0d..%0d cnt=%0d",
                     $time, result_valid, result_ovf, obj_found, sync_err, x_min, x_max, y_min, y_max, pix_count,
                     exp_rv, exp_ovf, exp_found, exp_sync, exp_xmin, exp_xmax, exp_ymin, exp_ymax, exp_cnt);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic rand_ack();
        return ack_rand && ($urandom_range(0, 7) == 0);
    endfunction

    // Called just after a rising edge; drives inputs for the next edge.
    task automatic step(input logic v, input logic m, input logic [9:0] x,
                        input logic [9:0] y, input logic a);
        valid = v; mask = m; mask_x = x; mask_y = y; result_ack = a;
        @(posedge clk_25);
        #1;
        model_edge(v, m, x, y, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom), 10'($urandom), 10'($urandom), rand_ack());
    endtask

    task automatic push_pix(input int x, input int y, input logic m);
        pix_t p;
        p.x = 10'(x); p.y = 10'(y); p.m = m;
        stim.push_back(p);
    endtask

    // Pixels xa..xb on row y, foreground where fa <= x <= fb.
    task automatic add_seg(input int y, input int xa, input int xb, input int fa, input int fb);
        for (int x = xa; x <= xb; x++) push_pix(x, y, !(x >= fa && x <= fb));
    endtask

    task automatic run_stim(input int gap_pct);
        foreach (stim[k]) begin
            while ($urandom_range(0, 99) < gap_pct)
                step(1'b0, 1'($urandom), 10'($urandom), 10'($urandom), rand_ack());
            step(1'b1, stim[k].m, stim[k].x, stim[k].y, rand_ack());
        end
        stim.delete();
    endtask

    task automatic rect_frame();
        push_pix(0, 0, 1'b1);
        for (int y = 49; y <= 60; y++) begin
            if (y >= 50 && y <= 59) add_seg(y, 0, XL, 100, 119);
            else                    add_seg(y, 0, XL, 1, 0);
        end
        push_pix(XL, YL, 1'b1);
    endtask

    task automatic edge_frame();
        push_pix(0, 0, 1'b1);
        add_seg(7, 630, 639, 636, 639);
        add_seg(8, 0, 5, 0, 1);
        push_pix(XL, YL, 1'b1);
    endtask

    task automatic random_frame();
        int  y, x, xa, len, rl, nrows;
        bit  fg;
        nrows = $urandom_range(2, 6);
        y = 0;
        push_pix(0, 0, 1'($urandom));
        for (int r = 0; r < nrows; r++) begin
            y = y + $urandom_range(1, 90);
            if (y > YL - 1) break;
            xa  = $urandom_range(0, 600);
            len = $urandom_range(4, 38);
            x   = xa;
            fg  = 1'($urandom);
            while (x <= xa + len) begin
                rl = fg ? $urandom_range(1, 9) : $urandom_range(1, 4);
                for (int k = 0; k < rl && x <= xa + len; k++) begin
                    push_pix(x, y, !fg);
                    x++;
                end
                if ($urandom_range(0, 5) == 0) x++;
                fg = !fg;
            end
        end
        push_pix(XL, YL, 1'($urandom));
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    initial begin
        #3600000;
        n_bad++;
        $display("FAIL watchdog: run did not complete within the time limit");
        finish_run();
    end

    initial begin
        reset_model();
        rst_n = 1'b0; enable = 1'b1; min_count = 20'd1;
        valid = 1'b0; mask = 1'b1; mask_x = 0; mask_y = 0; result_ack = 1'b0;
        @(posedge clk_25); @(posedge clk_25); #1;
        rst_n = 1'b1;

        // reset values
        check("rst_x_min", x_min, 10'h3FF);
        check("rst_y_min", y_min, 10'h3FF);
        check("rst_x_max", x_max, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_ovf", result_ovf, 0);
        idle(2);

        // rectangle 100..119 x 50..59, min_count=1
        rect_frame(); run_stim(10); idle(3);
        check("rect_rv", result_valid, 1);
        check("rect_x_min", x_min, 100);
        check("rect_x_max", x_max, 119);
        check("rect_y_min", y_min, 50);
        check("rect_y_max", y_max, 59);
        check("rect_count", pix_count, 200);
        check("rect_found", obj_found, 1);
        step(1'b0, 1'b1, 0, 0, 1'b1);
        check("rect_ack_clears", result_valid, 0);

        // same rectangle, threshold one above its count
        min_count = 20'd201;
        rect_frame(); run_stim(0); idle(3);
        check("thr_count", pix_count, 200);
        check("thr_found", obj_found, 0);
        step(1'b0, 1'b1, 0, 0, 1'b1);
        min_count = 20'd1;

        // only 3-pixel runs: nothing survives the filter
        push_pix(0, 0, 1'b1);
        for (int y = 5; y <= 20; y++) add_seg(y, 0, 31, 10, 12);
        push_pix(XL, YL, 1'b1);
        run_stim(10); idle(3);
        check("short_count", pix_count, 0);
        check("short_found", obj_found, 0);
        check("short_x_min", x_min, 10'h3FF);
        check("short_y_max", y_max, 0);
        step(1'b0, 1'b1, 0, 0, 1'b1);

        // run at the right edge of row 7, short run at start of row 8
        edge_frame(); run_stim(10); idle(3);
        check("edge_count", pix_count, 4);
        check("edge_x_min", x_min, 636);
        check("edge_x_max", x_max, 639);
        check("edge_y_min", y_min, 7);
        check("edge_y_max", y_max, 7);

        // overflow: two results without an ack
        step(1'b0, 1'b1, 0, 0, 1'b1);
        edge_frame(); run_stim(0); idle(3);
        check("ovf_first", result_ovf, 0);
        edge_frame(); run_stim(0); idle(3);
        check("ovf_second", result_ovf, 1);
        check("ovf_rv", result_valid, 1);
        step(1'b0, 1'b1, 0, 0, 1'b1);
        check("ovf_ack_rv", result_valid, 0);
        check("ovf_sticky", result_ovf, 1);

        // frame start injected mid-frame at row 240
        sync_hi = 0;
        push_pix(0, 0, 1'b1);
        add_seg(100, 15, 34, 20, 29);
        add_seg(101, 15, 34, 20, 29);
        add_seg(240, 0, 9, 1, 0);
        push_pix(0, 0, 1'b1);
        add_seg(300, 48, 59, 50, 57);
        add_seg(301, 48, 59, 50, 57);
        push_pix(XL, YL, 1'b1);
        run_stim(10); idle(3);
        check("sync_pulses", sync_hi, 1);
        check("sync_count", pix_count, 16);
        check("sync_y_min", y_min, 300);
        check("sync_x_min", x_min, 50);
        step(1'b0, 1'b1, 0, 0, 1'b1);

        // randomized frames, random enable/threshold/ack
        ack_rand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            enable    = ($urandom_range(0, 9) != 0);
            min_count = 20'($urandom_range(0, 40));
            random_frame();
            run_stim(15);
            idle($urandom_range(2, 5));
        end
        ack_rand = 1'b0;
        enable = 1'b1; min_count = 20'd1;

        // asynchronous reset in the middle of a frame
        edge_frame(); run_stim(0); idle(3);
        check("pre_rst_rv", result_valid, 1);
        check("pre_rst_ovf", result_ovf, 1);
        push_pix(0, 0, 1'b1);
        add_seg(7, 630, 639, 636, 639);
        run_stim(0);
        valid = 1'b0;
        #5 rst_n = 1'b0;
        #1;
        reset_model();
        check("async_rst_rv", result_valid, 0);
        check("async_rst_ovf", result_ovf, 0);
        check("async_rst_x_min", x_min, 10'h3FF);
        check("async_rst_x_max", x_max, 0);
        check("async_rst_count", pix_count, 0);
        check("async_rst_found", obj_found, 0);
        @(posedge clk_25); @(posedge clk_25); #1;
        rst_n = 1'b1;
        idle(2);
        edge_frame(); run_stim(5); idle(3);
        check("post_rst_count", pix_count, 4);
        check("post_rst_ovf", result_ovf, 0);

        finish_run();
    end

endmodule

// File: doc/mask_bbox_tracker.md
Name: mask_bbox_tracker

Overview:
- Downstream consumer of the per-pixel foreground mask stream (valid/mask/mask_x/mask_y, mask=0 means foreground).
- Filters out short horizontal foreground runs as noise.
- Accumulates, per frame, the bounding box and pixel count of the surviving foreground, then publishes one registered result per frame to the ALT side using a level/ack handshake.

Parameters:
- H_ACT, 640: active pixels per line; last column is H_ACT-1.
- V_ACT, 480: active lines per frame; last row is V_ACT-1.
- MIN_RUN, 4: minimum consecutive foreground pixels in a row before any of them count. Legal range 1..15.

Ports:
- clk_25  in  1  pixel clock.
- rst_n  in  1  reset.
- enable  in  1  tracking enable, sampled only at frame start.
- min_count  in  20  minimum pix_count for obj_found=1.
- valid  in  1  mask pixel strobe.
- mask  in  1  0 = foreground, 1 = background.
- mask_x  in  10  pixel column.
- mask_y  in  10  pixel row.
- result_valid  out  1  result registers hold an unacknowledged frame result.
- result_ack  in  1  clears result_valid.
- result_ovf  out  1  sticky: a new result overwrote an unacked one.
- obj_found  out  1  pix_count >= min_count and pix_count != 0.
- x_min, x_max, y_min, y_max  out  10 each  bounding box.
- pix_count  out  20  accepted foreground pixels in frame.
- sync_err  out  1  one-cycle pulse: frame start seen while mid-frame.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk_25.
- Reset values:
  - All outputs 0, except x_min=y_min=10'h3FF.
  - FSM in IDLE; run_len=0; accumulators cleared.
- Pixel input is consumed only on cycles with valid=1. With valid=0, no state changes except ack handling.
- Frame start (FS): valid && mask_x==0 && mask_y==0.
- Frame end (FE): valid && mask_x==H_ACT-1 && mask_y==V_ACT-1.
- FSM states:
  - IDLE: on FS with enable=1 → ACCUM. The FS pixel itself is processed with cleared accumulators (acc_xmin=acc_ymin=3FF, acc_xmax=acc_ymax=0, acc_cnt=0).
  - ACCUM: on FE → PUBLISH, with the FE pixel included. On FS (not FE) → sync_err pulse, accumulators re-cleared, stay in ACCUM; if enable=0 at that FS → IDLE instead.
  - PUBLISH: one cycle. Copies accumulators to outputs, computes obj_found, sets result_valid. If result_valid was already 1, sets result_ovf. Returns to IDLE, so the next FS re-arms.
- Run filter:
  - run_len (4-bit, saturating at 15) counts consecutive foreground pixels.
  - Reset to 0 on any mask=1 pixel, or when mask_x != prev_x+1 (new row or gap).
  - A foreground pixel that breaks continuity starts a new run with run_len=1 and run_start=mask_x.
  - When run_len becomes MIN_RUN: acc_cnt += MIN_RUN; acc_xmin=min(acc_xmin, run_start); acc_xmax=max(acc_xmax, mask_x); acc_ymin/acc_ymax updated with mask_y.
  - When run_len > MIN_RUN: acc_cnt += 1; acc_xmax, acc_ymax, acc_ymin updated with the current pixel.
  - acc_cnt saturates at 20'hFFFFF.
- Runs never span rows, because mask_x==0 always breaks continuity.
- Latency: FE pixel sampled at edge N. Outputs and result_valid update at edge N+1.
- Empty frame: pix_count=0, obj_found=0, and the box outputs carry the empty sentinels (x_min=y_min=3FF, x_max=y_max=0).
- Handshake:
  - result_ack=1 clears result_valid next edge.
  - If ack coincides with PUBLISH, PUBLISH wins: result_valid stays 1 and result_ovf is not set.
  - result_ovf clears only on reset.
- Output registers are stable between PUBLISH cycles.
- enable=0 mid-frame has no effect until the next FS.

Decomposition:
- Shared package holds:
  - H_ACT/V_ACT defaults.
  - Coordinate width constant (10).
  - Count width (20).
  - Empty-box sentinel constants.
  - FSM state encoding (IDLE/ACCUM/PUBLISH).
- One natural sub-module: mask_run_filter. It holds run_len, run_start and prev_x, and emits per-pixel accept/accept_burst/run_start to the accumulator.

Test Plan:
- Foreground rectangle x 100..119, y 50..59, rest background, full 640x480 frame, min_count=1 → one result_valid; x_min=100, x_max=119, y_min=50, y_max=59, pix_count=200, obj_found=1.
- Isolated 3-pixel runs only (MIN_RUN=4), e.g. x 10..12 on rows 5..20 → pix_count=0, obj_found=0, box = empty sentinels.
- Run x 636..639 on row 7 followed by x 0..1 on row 8 → pix_count=4 (row-8 run rejected); x_min=636, x_max=639, y_min=y_max=7.
- Rectangle as in the first scenario with min_count=201 → pix_count=200, obj_found=0.
- Two complete frames without result_ack → result_ovf=1 after the second PUBLISH; result_ack then clears result_valid while result_ovf stays 1.
- FS injected at row 240 mid-frame → sync_err single-cycle pulse; the published result covers only pixels after the restart. Also assert rst_n low mid-frame → all outputs return to reset values immediately.
